wb_ram_bus_mux_n: RTL
=====================

# wb_ram_bus_mux_n

Parametrised N-way Wishbone classic slave-side decoder. It sits between the Caravel management Wishbone port and N downstream memory controllers, such as OpenRAM and HyperRAM wrappers. It routes each transaction to one slave by base/mask address match, adds a per-transaction timeout, and returns a fixed error word for unmapped or timed-out accesses. A sticky error status records the failing address.

## Interface
Parameters:
- N_SLV, 2 — number of downstream slaves, 2..8.
- SLV_BASE, {32'h3000_0400, 32'h3000_0000} — packed N_SLV×32 base addresses; slot i occupies bits [32i+31:32i].
- SLV_MASK, {32'hFFFF_FC00, 32'hFFFF_FC00} — packed N_SLV×32 compare masks.
- TIMEOUT_CYCLES, 255 — maximum number of BUSY cycles to wait for a slave ack, 1..65535.
- ERR_DATA, 32'hDEAD_BEEF — read data returned on an error response.

Ports (clock and reset first):
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- wbs_ufp_stb_i, wbs_ufp_cyc_i, wbs_ufp_we_i  in  1 each  upstream strobe, cycle and write enable.
- wbs_ufp_sel_i  in  4  upstream byte selects.
- wbs_ufp_adr_i, wbs_ufp_dat_i  in  32 each  upstream address and write data.
- wbs_ufp_ack_o  out  1  upstream ack.
- wbs_ufp_dat_o  out  32  upstream read data.
- wbs_dfp_stb_o, wbs_dfp_cyc_o  out  N_SLV each  per-slave strobe and cycle; at most one bit high.
- wbs_dfp_we_o  out  1  write enable, shared by all slaves.
- wbs_dfp_sel_o  out  4  byte selects, shared by all slaves.
- wbs_dfp_adr_o, wbs_dfp_dat_o  out  32 each  address and write data, shared by all slaves.
- wbs_dfp_ack_i  in  N_SLV  per-slave ack.
- wbs_dfp_dat_i  in  32·N_SLV  packed per-slave read data.
- err_o  out  1  sticky error flag.
- err_adr_o  out  32  address of the first failing access since the last clear.
- err_clr_i  in  1  synchronous clear of err_o and err_adr_o.

## Operation
- The state machine has three states: IDLE, BUSY and RESP.
- IDLE, with ufp cyc&stb sampled high:
  - Decode: slot i matches when (adr & MASK_i) == (BASE_i & MASK_i). When several slots match, the lowest index wins.
  - Register adr, dat, sel and we into the dfp shared outputs, and register the selected index.
  - On a hit: go to BUSY, assert dfp_cyc/stb[sel].
  - On a miss: go to RESP with the error flag set.
- BUSY:
  - dfp_cyc/stb[sel] stay high and the timeout counter increments.
  - ack_i[sel] high: capture dat_i[sel] into ufp_dat_o, drop dfp cyc/stb, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop dfp cyc/stb, go to RESP with the error flag set.
  - ufp_cyc_i low (master abort): drop dfp cyc/stb, go to IDLE, issue no ack, set no error.
  - ack_i from any non-selected slot is ignored in every state.
- RESP:
  - ufp_ack_o is high for exactly one cycle, then the state returns to IDLE.
  - On an error response, ufp_dat_o = ERR_DATA.
  - On an error response, err_o is set; err_adr_o is loaded only if err_o was previously 0 (first-error capture).
- err_clr_i clears err_o and err_adr_o on the next edge. An error event in the same cycle wins: err_o stays set and err_adr_o is loaded with the new address.
- Writes that hit no slot or time out are dropped and still acked, with the error flag set.

## Timing
- Reset (asynchronous, any state): state = IDLE; all dfp outputs, ufp_ack_o, ufp_dat_o, err_o, err_adr_o and the timeout counter go to 0. A transaction interrupted by reset is lost; no ack is issued after reset.
- Hit latency: the request is sampled at edge 0, dfp stb is high after edge 0, and ack_i is sampled at edge k. ufp_ack_o is high in the cycle after edge k. The minimum is 2 cycles from request to ack, when the slave acks in the first BUSY cycle.
- Miss latency: ufp_ack_o is high in the cycle after the sampling edge.
- Timeout: dfp stb is high for exactly TIMEOUT_CYCLES cycles, then ufp_ack_o pulses in the next cycle.
- A new request is accepted only in IDLE. The cycle after RESP is IDLE, so back-to-back transactions run with a 1-cycle gap minimum.
- The timeout counter is 16 bits and resets to 0 on every IDLE→BUSY transition.

## Test plan
- Read hit, slot 1, N_SLV=2: read 0x3000_0404; slave 1 acks after 3 cycles with 0x1234_5678. Required: only dfp_stb[1] asserts; ufp_ack_o pulses once with dat 0x1234_5678; err_o=0.
- Unmapped access: write 0x3000_0800. Required: no dfp stb; ufp_ack_o 1 cycle after the request; err_o=1; err_adr_o=0x3000_0800.
- Timeout, TIMEOUT_CYCLES=4: slave 0 never acks. Required: dfp_stb[0] high for exactly 4 cycles; ufp_ack_o with 0xDEAD_BEEF; err_o set.
- First-error capture and clear: two errors at A then B, then pulse err_clr_i. Required: err_adr_o=A until the clear, then 0 with err_o=0. Repeat with the clear coincident with an error at C: err_o stays 1, err_adr_o=C.
- Abort and spurious ack: ufp_cyc drops mid-BUSY; slave 1 acks while slot 0 is selected. Required: dfp cyc/stb drop the next cycle; no ufp ack; the spurious ack is ignored.
- Async reset pulse in BUSY, driven between clock edges. Required: all outputs are 0 immediately; a subsequent read hit completes normally.

Source files
------------

// File: rtl/wb_ram_bus_mux_n.sv
// N-way Wishbone classic decoder with per-transaction timeout,
// fixed error read data and sticky first-error address capture.
module wb_ram_bus_mux_n #(
  parameter int unsigned N_SLV = 2,
  parameter logic [32*N_SLV-1:0] SLV_BASE = {32'h3000_0400, 32'h3000_0000},
  parameter logic [32*N_SLV-1:0] SLV_MASK = {32'hFFFF_FC00, 32'hFFFF_FC00},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 wbs_ufp_stb_i,
  input  logic                 wbs_ufp_cyc_i,
  input  logic                 wbs_ufp_we_i,
  input  logic [3:0]           wbs_ufp_sel_i,
  input  logic [31:0]          wbs_ufp_adr_i,
  input  logic [31:0]          wbs_ufp_dat_i,
  output logic                 wbs_ufp_ack_o,
  output logic [31:0]          wbs_ufp_dat_o,
  output logic [N_SLV-1:0]     wbs_dfp_stb_o,
  output logic [N_SLV-1:0]     wbs_dfp_cyc_o,
  output logic                 wbs_dfp_we_o,
  output logic [3:0]           wbs_dfp_sel_o,
  output logic [31:0]          wbs_dfp_adr_o,
  output logic [31:0]          wbs_dfp_dat_o,
  input  logic [N_SLV-1:0]     wbs_dfp_ack_i,
  input  logic [32*N_SLV-1:0]  wbs_dfp_dat_i,
  output logic                 err_o,
  output logic [31:0]          err_adr_o,
  input  logic                 err_clr_i
);

  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_SLV-1:0] stb_q, stb_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     rdat_q, rdat_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     err_adr_q, err_adr_d;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            err_evt;
  logic [31:0]     err_evt_adr;
  logic            req;

  assign req = wbs_ufp_cyc_i & wbs_ufp_stb_i;

  // Scan downward so the lowest matching slot wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((wbs_ufp_adr_i & SLV_MASK[32*i +: 32]) ==
          (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rdat_d      = rdat_q;
    cnt_d       = cnt_q;
    err_evt     = 1'b0;
    err_evt_adr = adr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = wbs_ufp_adr_i;
          dat_d = wbs_ufp_dat_i;
          sel_d = wbs_ufp_sel_i;
          we_d  = wbs_ufp_we_i;
          idx_d = hit_idx;
          cnt_d = '0;
          if (hit) begin
            state_d = BUSY;
            stb_d   = N_SLV'(1) << hit_idx;
          end else begin
            state_d     = RESP;
            rdat_d      = ERR_DATA;
            err_evt     = 1'b1;
            err_evt_adr = wbs_ufp_adr_i;
          end
        end
      end
      BUSY: begin
        if (!wbs_ufp_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (wbs_dfp_ack_i[idx_q]) begin
          stb_d   = '0;
          rdat_d  = wbs_dfp_dat_i[32*idx_q +: 32];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
            stb_d   = '0;
            rdat_d  = ERR_DATA;
            err_evt = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new error beats a coincident clear and re-arms the capture.
  always_comb begin
    err_d     = err_q;
    err_adr_d = err_adr_q;
    if (err_evt) begin
      err_d = 1'b1;
      if (!err_q || err_clr_i) err_adr_d = err_evt_adr;
    end else if (err_clr_i) begin
      err_d     = 1'b0;
      err_adr_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      stb_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdat_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rdat_q    <= rdat_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  assign wbs_ufp_ack_o = (state_q == RESP);
  assign wbs_ufp_dat_o = rdat_q;
  assign wbs_dfp_stb_o = stb_q;
  assign wbs_dfp_cyc_o = stb_q;
  assign wbs_dfp_we_o  = we_q;
  assign wbs_dfp_sel_o = sel_q;
  assign wbs_dfp_adr_o = adr_q;
  assign wbs_dfp_dat_o = dat_q;
  assign err_o         = err_q;
  assign err_adr_o     = err_adr_q;

endmodule
